// File: rtl/arb_prio_fun_if.sv
// arb_prio_fun_if: request/grant bundle between profile selection and the functionality arbiter
interface arb_prio_fun_if #(parameter int N_PERF = 4, parameter int FUN_W = 3);
  logic [N_PERF-1:0] req;
  logic [N_PERF*FUN_W-1:0] fun;
  logic [N_PERF-1:0] prio;
  logic [N_PERF-1:0] rel;
  logic [N_PERF-1:0] gnt;
  logic [FUN_W-1:0] gnt_fun;
  logic busy;
  logic conf;
  logic tout;
  modport master (output req, fun, prio, rel, input gnt, gnt_fun, busy, conf, tout);
  modport slave (input req, fun, prio, rel, output gnt, gnt_fun, busy, conf, tout);
endinterface

// File: rtl/arb_prio_fun.sv
// arb_prio_fun: priority/round-robin arbiter granting all profiles that share the winner's functionality
// ARB_PRIO_TIMEOUT_EN compiles in the grant cycle counter and forced release after TMO cycles.
module arb_prio_fun #(
  parameter int N_PERF = 4,
  parameter int FUN_W = 3,
  parameter int TMO = 8
) (
  input logic clk,
  input logic rst_n,
  arb_prio_fun_if.slave bus
);
  localparam int PW = (N_PERF > 1) ? $clog2(N_PERF) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [PW-1:0] ptr, ptr_d, win, win_q, win_d;
  logic [N_PERF-1:0] cand, match, gnt, gnt_d;
  logic [FUN_W-1:0] gnt_fun, gnt_fun_d;
  logic busy, busy_d, conf, conf_d, tout, tout_d, rel_end, tmo_end;
  assign cand = |(bus.req & bus.prio) ? bus.req & bus.prio : bus.req;
  // descending scan so the candidate closest to ptr is the last write
  always_comb begin
    win = '0;
    for (int k = N_PERF - 1; k >= 0; k--)
      if (cand[(int'(ptr) + k) % N_PERF]) win = PW'((int'(ptr) + k) % N_PERF);
  end
  always_comb begin
    match = '0;
    for (int i = 0; i < N_PERF; i++)
      match[i] = bus.req[i] && (bus.fun[i*FUN_W +: FUN_W] == bus.fun[win*FUN_W +: FUN_W]);
  end
  assign rel_end = |(bus.rel & gnt) || ~|(bus.req & gnt);
`ifdef ARB_PRIO_TIMEOUT_EN
  localparam int CW = $clog2(TMO);
  logic [CW-1:0] cnt, cnt_d;
  assign tmo_end = state == GRANT && cnt == CW'(TMO - 1);
  assign cnt_d = state == IDLE ? '0 : (cnt == CW'(TMO - 1) ? cnt : cnt + 1'b1);
  always_ff @(posedge clk)
    cnt <= !rst_n ? '0 : cnt_d;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO;
  assign tmo_end = 1'b0;
`endif
  always_comb begin
    state_d = state;
    gnt_d = gnt;
    gnt_fun_d = gnt_fun;
    busy_d = busy;
    conf_d = conf;
    tout_d = 1'b0;
    ptr_d = ptr;
    win_d = win_q;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_d = GRANT;
        gnt_d = match;
        gnt_fun_d = bus.fun[win*FUN_W +: FUN_W];
        busy_d = 1'b1;
        conf_d = |(bus.req & ~match);
        win_d = win;
      end
    end else if (rel_end || tmo_end) begin
      state_d = IDLE;
      gnt_d = '0;
      gnt_fun_d = '0;
      busy_d = 1'b0;
      conf_d = 1'b0;
      ptr_d = win_q == PW'(N_PERF - 1) ? '0 : win_q + 1'b1;
      tout_d = tmo_end && !rel_end;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_fun <= '0;
      busy <= 1'b0;
      conf <= 1'b0;
      tout <= 1'b0;
      ptr <= '0;
      win_q <= '0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      gnt_fun <= gnt_fun_d;
      busy <= busy_d;
      conf <= conf_d;
      tout <= tout_d;
      ptr <= ptr_d;
      win_q <= win_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.gnt_fun = gnt_fun;
  assign bus.busy = busy;
  assign bus.conf = conf;
  assign bus.tout = tout;
endmodule

// File: tb/tb_arb_prio_fun.sv
// tb_arb_prio_fun: directed and random checks of arb_prio_fun against a behavioural model
module tb_arb_prio_fun;
  localparam int N = 4;
  localparam int FW = 3;
  localparam int TMO = 8;
`ifdef ARB_PRIO_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  arb_prio_fun_if #(.N_PERF(N), .FUN_W(FW)) bus();
  arb_prio_fun #(.N_PERF(N), .FUN_W(FW), .TMO(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_gnt;
  logic [FW-1:0] m_fun;
  logic m_busy, m_conf, m_tout;
  int m_ptr, m_win, m_cnt;
  function automatic logic [FW-1:0] fun_of(int i);
    return bus.fun[i*FW +: FW];
  endfunction
  task automatic model();
    if (!rst_n) begin
      m_gnt = '0; m_fun = '0; m_busy = 0; m_conf = 0; m_tout = 0;
      m_ptr = 0; m_win = 0; m_cnt = 0;
    end else if (!m_busy) begin
      m_tout = 0;
      if (bus.req != 0) begin
        logic [N-1:0] c;
        c = (bus.req & bus.prio) != 0 ? bus.req & bus.prio : bus.req;
        m_win = -1;
        for (int k = 0; k < N; k++)
          if (m_win < 0 && c[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        m_fun = fun_of(m_win);
        m_gnt = '0;
        for (int i = 0; i < N; i++) m_gnt[i] = bus.req[i] && fun_of(i) == m_fun;
        m_conf = (bus.req & ~m_gnt) != 0;
        m_busy = 1;
        m_cnt = 0;
      end
    end else begin
      bit er, et;
      er = (bus.rel & m_gnt) != 0 || (bus.req & m_gnt) == 0;
      et = TEN && m_cnt == TMO - 1;
      if (er || et) begin
        m_gnt = '0; m_fun = '0; m_busy = 0; m_conf = 0;
        m_ptr = (m_win + 1) % N;
        m_tout = et && !er;
      end else begin
        m_cnt = m_cnt < TMO - 1 ? m_cnt + 1 : m_cnt;
        m_tout = 0;
      end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("gnt", bus.gnt, m_gnt);
    chk("gnt_fun", bus.gnt_fun, m_fun);
    chk("busy", bus.busy, m_busy);
    chk("conf", bus.conf, m_conf);
    chk("tout", bus.tout, m_tout);
  endtask
  task automatic set_fun(input int a, input int b, input int c, input int d);
    bus.fun = {FW'(d), FW'(c), FW'(b), FW'(a)};
  endtask
  initial begin
    int n;
    bus.req = 4'b1111; bus.prio = '0; bus.rel = '0; set_fun(0, 1, 2, 3);
    rst_n = 0;
    step(); step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tout", bus.tout, 0);
    rst_n = 1; bus.req = '0;
    step();
    set_fun(3, 1, 3, 6); bus.req = 4'b0101;
    step();
    chk("eq_gnt", bus.gnt, 4'b0101);
    chk("eq_fun", bus.gnt_fun, 3);
    chk("eq_conf", bus.conf, 0);
    chk("eq_busy", bus.busy, 1);
    bus.rel = 4'b0001;
    step();
    bus.rel = '0; bus.req = '0;
    step();
    set_fun(0, 2, 5, 0); bus.req = 4'b0110; bus.prio = 4'b0100;
    step();
    chk("pr_gnt", bus.gnt, 4'b0100);
    chk("pr_fun", bus.gnt_fun, 5);
    chk("pr_conf", bus.conf, 1);
    bus.rel = 4'b0100; bus.req = 4'b0010; bus.prio = '0;
    step();
    chk("pr_rel_gnt", bus.gnt, 0);
    bus.rel = '0;
    step();
    chk("pr2_gnt", bus.gnt, 4'b0010);
    chk("pr2_fun", bus.gnt_fun, 2);
    chk("pr2_conf", bus.conf, 0);
    rst_n = 0; bus.req = 4'b1111; set_fun(0, 1, 2, 3);
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_gnt", bus.gnt, 32'(1 << (i % 4)));
      step();
      bus.rel = 4'b1111;
      step();
      bus.rel = '0;
    end
    rst_n = 0;
    step();
    rst_n = 1; bus.req = 4'b0001;
    step();
    n = 0;
    while (bus.gnt == 4'b0001 && n < 30) begin
      n++;
      step();
    end
`ifdef ARB_PRIO_TIMEOUT_EN
    chk("to_len", n, 8);
    chk("to_tout", bus.tout, 1);
    step();
    chk("to_regnt", bus.gnt, 4'b0001);
    chk("to_tout_off", bus.tout, 0);
`else
    chk("to_len", n, 30);
    chk("to_tout", bus.tout, 0);
`endif
    rst_n = 0;
    step();
    rst_n = 1; bus.req = 4'b0010;
    step();
    chk("mg_gnt", bus.gnt, 4'b0010);
    rst_n = 0;
    step();
    chk("mg_gnt0", bus.gnt, 0);
    chk("mg_busy", bus.busy, 0);
    rst_n = 1; bus.req = 4'b1111;
    step();
    chk("mg_next", bus.gnt, 4'b0001);
    for (int c = 0; c < 600; c++) begin
      rst_n = $urandom_range(99) != 0;
      if ($urandom_range(3) == 0) bus.req = 4'($urandom);
      for (int i = 0; i < N; i++) bus.fun[i*FW +: FW] = FW'($urandom_range(3));
      bus.prio = $urandom_range(3) == 0 ? 4'($urandom) : '0;
      bus.rel = $urandom_range(5) == 0 ? 4'($urandom) : '0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
